// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data memory responder.
//   - dmem_state_t  : FSM state encodings (IDLE / WAIT / RESP)
//   - FAULT_PATTERN : load data returned for a faulting access
//   - CNT_W         : wait-state counter width (LATENCY must be <= 2**CNT_W)
package data_memory_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    localparam logic [31:0] FAULT_PATTERN = 32'hDEADBEEF;
    localparam int          CNT_W         = 8;

endpackage

// File: rtl/data_memory_responder_sram_array.sv
// dmem_sram_array: single-port MEM_WORDS x 32 storage, synchronous write and
// synchronous read, no reset on contents or read register.
// Ports:
//   clk    in   clock, rising edge
//   en     in   access enable for this cycle
//   we     in   1 = write wdata at addr, 0 = read addr into rdata
//   addr   in   word index
//   wdata  in   store data
//   rdata  out  registered load data; holds until the next read
module dmem_sram_array #(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: word-wide memory slave on the core's data bus.
// Accepts a level read/write request in IDLE, waits LATENCY-1 cycles, then
// pulses data_memory_response for one cycle with the load data.
// A request accepted at edge N gives response high in cycle N+LATENCY.
// Optional feature macro: DMEM_FAULT_EN (out-of-range accesses fault and
// return 32'hDEADBEEF; otherwise the word index wraps modulo MEM_WORDS).
// Ports:
//   clk                  in   clock, rising edge
//   reset                in   asynchronous active-low reset
//   data_memory_read     in   read request, held until response
//   data_memory_write    in   write request, held until response (wins over read)
//   data_address         in   byte address, bits [1:0] ignored
//   write_data           in   store data
//   data_memory_response out  one-cycle completion pulse
//   read_data            out  load data, valid in response cycle, held after
//   access_fault         out  fault flag in response cycle (0 without DMEM_FAULT_EN)
//   debug_state          out  current FSM state (dmem_state_t encoding)
// LATENCY must be >= 1 and <= 2**CNT_W.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_memory_read,
    input  logic        data_memory_write,
    input  logic [31:0] data_address,
    input  logic [31:0] write_data,
    output logic        data_memory_response,
    output logic [31:0] read_data,
    output logic        access_fault,
    output logic [1:0]  debug_state
);

    localparam int AW = $clog2(MEM_WORDS);

    dmem_state_t      state, next_state;
    logic [CNT_W-1:0] count;
    logic             op_write;
    logic [AW-1:0]    idx_q;
    logic [31:0]      wdata_q;
    logic             fault_q;
    logic             sel_sram;
    logic [31:0]      hold_q;
    logic [31:0]      sram_q;

    logic             request;
    logic             accept;
    logic             enter_resp;
    logic [AW-1:0]    req_idx;
    logic             req_fault;
    logic             cur_write;
    logic             cur_fault;
    logic [AW-1:0]    cur_idx;
    logic [31:0]      cur_wdata;

    assign request = data_memory_read | data_memory_write;
    assign accept  = (state == ST_IDLE) && request;

    // Truncation to AW bits gives the modulo-MEM_WORDS wrap.
    assign req_idx = AW'((data_address - BASE_ADDR) >> 2);

`ifdef DMEM_FAULT_EN
    assign req_fault = (data_address < BASE_ADDR) ||
                       (((data_address - BASE_ADDR) >> 2) >= 32'(MEM_WORDS));
`else
    assign req_fault = 1'b0;
`endif

    // With LATENCY==1 the SRAM is accessed on the accept edge itself, so the
    // live request drives the array in IDLE; otherwise the latched copy does.
    assign cur_write = (state == ST_IDLE) ? data_memory_write : op_write;
    assign cur_fault = (state == ST_IDLE) ? req_fault         : fault_q;
    assign cur_idx   = (state == ST_IDLE) ? req_idx           : idx_q;
    assign cur_wdata = (state == ST_IDLE) ? write_data        : wdata_q;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (request) next_state = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            // count holds the cycles still to go; the last one is the RESP entry edge
            ST_WAIT: if (count <= CNT_W'(1)) next_state = ST_RESP;
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    assign enter_resp = (next_state == ST_RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            op_write <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            fault_q  <= 1'b0;
            sel_sram <= 1'b0;
            hold_q   <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                op_write <= data_memory_write;
                idx_q    <= req_idx;
                wdata_q  <= write_data;
                fault_q  <= req_fault;
                count    <= CNT_W'(LATENCY - 1);
            end else if (state == ST_WAIT) begin
                count <= count - CNT_W'(1);
            end
            // read_data comes from the SRAM read register after a good read,
            // otherwise from hold_q; writes leave the selection untouched.
            if (enter_resp) begin
                if (cur_fault) begin
                    sel_sram <= 1'b0;
                    hold_q   <= FAULT_PATTERN;
                end else if (!cur_write) begin
                    sel_sram <= 1'b1;
                end
            end
        end
    end

    dmem_sram_array #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_sram (
        .clk   (clk),
        .en    (enter_resp && !cur_fault),
        .we    (cur_write),
        .addr  (cur_idx),
        .wdata (cur_wdata),
        .rdata (sram_q)
    );

    assign data_memory_response = (state == ST_RESP);
    assign read_data            = sel_sram ? sram_q : hold_q;
    assign debug_state          = state;

`ifdef DMEM_FAULT_EN
    assign access_fault = (state == ST_RESP) && fault_q;
`else
    assign access_fault = 1'b0;
`endif

endmodule
